// File: rtl/des_mode_ctrl_pkg.sv
// des_ctrl_pkg: shared types and constants for the DES mode controller.
// Holds the controller state enum, mode encodings and block width.
package des_ctrl_pkg;

    localparam int DES_BLK_W = 64;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/des_mode_ctrl_if.sv
// des_mode_ctrl_if: input/output block valid-ready handshakes.
// slave is the controller side, master is the producer/consumer side.
interface des_mode_ctrl_if;
    import des_ctrl_pkg::*;

    logic                 i_InValid;
    logic                 o_InReady;
    logic [DES_BLK_W-1:0] i_InData;
    logic                 o_OutValid;
    logic                 i_OutReady;
    logic [DES_BLK_W-1:0] o_OutData;

    modport slave (
        input  i_InValid,
        input  i_InData,
        input  i_OutReady,
        output o_InReady,
        output o_OutValid,
        output o_OutData
    );

    modport master (
        output i_InValid,
        output i_InData,
        output i_OutReady,
        input  o_InReady,
        input  o_OutValid,
        input  o_OutData
    );

endinterface

// File: rtl/des_mode_ctrl.sv
// des_mode_ctrl: ECB/CBC block sequencer driving an external DES core.
// Define DES_MODE_CTRL_CBC_EN for CBC chaining; undefined builds ECB only.
module des_mode_ctrl
    import des_ctrl_pkg::*;
(
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    des_mode_ctrl_if.slave       bus,
    input  logic                 i_MsgStart,
    input  logic [DES_BLK_W-1:0] i_Key,
    input  logic                 i_Dec,
    input  logic                 i_Mode,
    input  logic [DES_BLK_W-1:0] i_IV,
    output logic                 o_Busy,
    output logic                 o_DesStart,
    output logic                 o_DesDec,
    output logic [DES_BLK_W-1:0] o_DesData,
    output logic [DES_BLK_W-1:0] o_DesKey,
    input  logic [DES_BLK_W-1:0] i_DesData,
    input  logic                 i_DesDone
);

    state_t               state_q;
    state_t               state_d;
    logic [DES_BLK_W-1:0] key_q;
    logic                 dec_q;
    logic [DES_BLK_W-1:0] des_data_q;
    logic [DES_BLK_W-1:0] out_data_q;
    logic [DES_BLK_W-1:0] des_in;
    logic                 eff_dec;
    logic                 in_ready;
    logic                 out_valid;
    logic                 busy;
    logic                 des_start;
    logic                 idle;
    logic                 accept;
    logic                 msg_ok;
    logic                 capture;

    assign idle    = (state_q == IDLE);
    assign accept  = idle && bus.i_InValid;
    assign msg_ok  = idle && i_MsgStart;
    assign capture = (state_q == WAIT) && i_DesDone;
    assign eff_dec = msg_ok ? i_Dec : dec_q;

`ifdef DES_MODE_CTRL_CBC_EN
    logic                 mode_q;
    logic [DES_BLK_W-1:0] chain_q;
    logic [DES_BLK_W-1:0] blk_q;
    logic                 eff_mode;
    logic [DES_BLK_W-1:0] eff_chain;

    // A message start alongside a block must already steer that block.
    always_comb begin
        eff_mode  = msg_ok ? i_Mode : mode_q;
        eff_chain = msg_ok ? i_IV : chain_q;
        des_in    = bus.i_InData;
        if (eff_mode == MODE_CBC && !eff_dec)
            des_in = bus.i_InData ^ eff_chain;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{i_Mode, i_IV};
    assign des_in     = bus.i_InData;
`endif

    // Next-state and handshake/core strobes.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        des_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.i_InValid)
                    state_d = START;
            end
            START: begin
                des_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (i_DesDone)
                    state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (bus.i_OutReady)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, message parameters, core operand and result registers.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q    <= IDLE;
            key_q      <= '0;
            dec_q      <= 1'b0;
            des_data_q <= '0;
            out_data_q <= '0;
`ifdef DES_MODE_CTRL_CBC_EN
            mode_q     <= MODE_ECB;
            chain_q    <= '0;
            blk_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (msg_ok) begin
                key_q   <= i_Key;
                dec_q   <= i_Dec;
`ifdef DES_MODE_CTRL_CBC_EN
                mode_q  <= i_Mode;
                chain_q <= i_IV;
`endif
            end
            if (accept) begin
                des_data_q <= des_in;
`ifdef DES_MODE_CTRL_CBC_EN
                blk_q      <= bus.i_InData;
`endif
            end
            if (capture) begin
`ifdef DES_MODE_CTRL_CBC_EN
                if (mode_q == MODE_CBC && dec_q) begin
                    out_data_q <= i_DesData ^ chain_q;
                    chain_q    <= blk_q;
                end else begin
                    out_data_q <= i_DesData;
                    if (mode_q == MODE_CBC)
                        chain_q <= i_DesData;
                end
`else
                out_data_q <= i_DesData;
`endif
            end
        end
    end

    assign bus.o_InReady  = in_ready;
    assign bus.o_OutValid = out_valid;
    assign bus.o_OutData  = out_data_q;
    assign o_Busy         = busy;
    assign o_DesStart     = des_start;
    assign o_DesDec       = dec_q;
    assign o_DesData      = des_data_q;
    assign o_DesKey       = key_q;

endmodule

// File: tb/tb_des_mode_ctrl.sv
// tb_des_mode_ctrl: directed bench with a behavioural DES core and a
// scoreboard of expected output blocks for des_mode_ctrl.
module tb_des_mode_ctrl;
    import des_ctrl_pkg::*;

`ifdef DES_MODE_CTRL_CBC_EN
    localparam bit CBC_EN = 1'b1;
`else
    localparam bit CBC_EN = 1'b0;
`endif

    localparam logic [63:0] K = 64'h133457799BBCDFF1;
    localparam logic [63:0] P = 64'h0123456789ABCDEF;
    localparam logic [63:0] C = 64'h85E813540F0AB405;

    localparam int IP [64] = '{
        58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP [64] = '{
        40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int EX [48] = '{
        32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,
        12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,
        22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int PP [32] = '{
        16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1 [56] = '{
        57,49,41,33,25,17,9,1,58,50,42,34,26,18,
        10,2,59,51,43,35,27,19,11,3,60,52,44,36,
        63,55,47,39,31,23,15,7,62,54,46,38,30,22,
        14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{
        14,17,11,24,1,5,3,28,15,6,21,10,
        23,19,12,4,26,8,16,7,27,20,13,2,
        41,52,31,37,47,55,30,40,51,45,33,48,
        44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SB [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
        0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
        15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
        3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
        13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
        13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
        1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
        13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
        3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
        14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
        11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
        10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
        4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
        13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
        6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
        1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
        2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] des(input logic [63:0] k,
                                        input logic [63:0] b,
                                        input logic d);
        logic [55:0] cd;
        logic [27:0] c, dd;
        logic [47:0] ks [16];
        logic [47:0] e;
        logic [63:0] ip, pre, res;
        logic [31:0] l, r, f, t, so;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
        c  = cd[55:28];
        dd = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SH[n]; s++) begin
                c  = {c[26:0], c[27]};
                dd = {dd[26:0], dd[27]};
            end
            cd = {c, dd};
            for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2[i]];
        end
        for (int i = 0; i < 64; i++) ip[63-i] = b[64-IP[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-EX[i]];
            e = e ^ (d ? ks[15-n] : ks[n]);
            for (int s = 0; s < 8; s++) begin
                six = e[47-6*s -: 6];
                idx = s*64 + 32*int'(six[5]) + 16*int'(six[0])
                      + int'(six[4:1]);
                so[31-4*s -: 4] = 4'(SB[idx]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = so[32-PP[i]];
            t = l ^ f;
            l = r;
            r = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP[i]];
        return res;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ms, dec, mode;
    logic [63:0] key, iv;
    logic        busy, ds, ddec, cdone;
    logic [63:0] ddata, dkey, cdata;
    logic [4:0]  ccnt;
    int          cyc = 0;
    int          t_hs = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb [$];
    logic [63:0] m_key, m_chain;
    logic        m_dec, m_mode;
    logic [63:0] g1, g2, g3;

    always #5 clk = ~clk;

    des_mode_ctrl_if bus ();

    des_mode_ctrl dut (
        .i_Clk      (clk),
        .i_Reset    (rst_n),
        .bus        (bus.slave),
        .i_MsgStart (ms),
        .i_Key      (key),
        .i_Dec      (dec),
        .i_Mode     (mode),
        .i_IV       (iv),
        .o_Busy     (busy),
        .o_DesStart (ds),
        .o_DesDec   (ddec),
        .o_DesData  (ddata),
        .o_DesKey   (dkey),
        .i_DesData  (cdata),
        .i_DesDone  (cdone)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: 16 round cycles then a one-cycle done strobe.
    always @(posedge clk) begin
        if (ds) begin
            cdata <= des(dkey, ddata, ddec);
            ccnt  <= 5'd1;
            cdone <= 1'b0;
        end else if (ccnt == 5'd17) begin
            cdone <= 1'b1;
            ccnt  <= 5'd0;
        end else begin
            cdone <= 1'b0;
            if (ccnt != 5'd0) ccnt <= ccnt + 5'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_key = '0; m_dec = 1'b0; m_mode = 1'b0; m_chain = '0;
    endtask

    task automatic send(input logic [63:0] blk, input bit wm,
                        input logic [63:0] k, input logic d,
                        input logic m, input logic [63:0] v);
        logic [63:0] din, exp;
        int n;
        n = 0;
        while (!bus.o_InReady && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_InReady) begin
            check("in_timeout", {63'd0, bus.o_InReady}, 64'd1);
            return;
        end
        if (wm) begin
            ms = 1'b1; key = k; dec = d; mode = m; iv = v;
            m_key = k; m_dec = d; m_mode = m; m_chain = v;
        end
        din = blk;
        if (CBC_EN && m_mode && !m_dec) begin
            din = blk ^ m_chain;
            exp = des(m_key, din, 1'b0);
            m_chain = exp;
        end else if (CBC_EN && m_mode) begin
            exp = des(m_key, blk, 1'b1) ^ m_chain;
            m_chain = blk;
        end else begin
            exp = des(m_key, blk, m_dec);
        end
        sb.push_back(exp);
        bus.i_InValid = 1'b1;
        bus.i_InData  = blk;
        @(posedge clk);
        @(negedge clk);
        t_hs = cyc;
        bus.i_InValid = 1'b0;
        ms = 1'b0;
        check("start_strobe", {63'd0, ds}, 64'd1);
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_inrdy", {63'd0, bus.o_InReady}, 64'd0);
        check("des_data", ddata, din);
        check("des_key", dkey, m_key);
        check("des_dec", {63'd0, ddec}, {63'd0, m_dec});
        @(negedge clk);
        check("start_once", {63'd0, ds}, 64'd0);
        check("des_data_hold", ddata, din);
    endtask

    task automatic recv(input int stall, output logic [63:0] got);
        logic [63:0] first, exp;
        int n;
        n = 0;
        got = '0;
        while (!bus.o_OutValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_OutValid) begin
            check("out_timeout", {63'd0, bus.o_OutValid}, 64'd1);
            return;
        end
        check("latency", 64'(cyc - t_hs), 64'd19);
        first = bus.o_OutData;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, bus.o_OutValid}, 64'd1);
            check("bp_stable", bus.o_OutData, first);
            check("bp_inrdy", {63'd0, bus.o_InReady}, 64'd0);
        end
        got = bus.o_OutData;
        if (sb.size() == 0) begin
            check("sb_empty", got, ~got);
        end else begin
            exp = sb.pop_front();
            check("out_data", got, exp);
        end
        bus.i_OutReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_OutReady = 1'b0;
        check("post_valid", {63'd0, bus.o_OutValid}, 64'd0);
        check("post_inrdy", {63'd0, bus.o_InReady}, 64'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_inrdy"}, {63'd0, bus.o_InReady}, 64'd1);
        check({tag, "_ovalid"}, {63'd0, bus.o_OutValid}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_dstart"}, {63'd0, ds}, 64'd0);
        check({tag, "_ddec"}, {63'd0, ddec}, 64'd0);
        check({tag, "_ddata"}, ddata, 64'd0);
        check({tag, "_dkey"}, dkey, 64'd0);
        check({tag, "_odata"}, bus.o_OutData, 64'd0);
    endtask

    initial begin
        bus.i_InValid = 1'b0; bus.i_InData = '0; bus.i_OutReady = 1'b0;
        ms = 1'b0; key = '0; dec = 1'b0; mode = 1'b0; iv = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        send(P, 1'b1, K, 1'b0, MODE_ECB, 64'd0);
        recv(0, g1);
        check("ecb_enc_kat", g1, C);
        send(C, 1'b1, K, 1'b1, MODE_ECB, 64'd0);
        recv(0, g1);
        check("ecb_dec_kat", g1, P);

        send(P, 1'b1, K, 1'b0, MODE_CBC, 64'd0);
        recv(0, g1);
        check("cbc_enc_first", g1, C);
        send(P, 1'b0, K, 1'b0, MODE_CBC, 64'd0);
        recv(0, g2);
        send(g1, 1'b1, K, 1'b1, MODE_CBC, 64'd0);
        recv(0, g3);
        check("cbc_dec_first", g3, P);
        send(g2, 1'b0, K, 1'b1, MODE_CBC, 64'd0);
        recv(0, g3);
        check("cbc_dec_second", g3, P);

        send(64'hDEADBEEFCAFEF00D, 1'b1, 64'h0E329232EA6D0D73,
             1'b0, MODE_ECB, 64'd0);
        recv(10, g1);

        send(64'h1122334455667788, 1'b1, K, 1'b0, MODE_CBC,
             64'hA5A5A5A55A5A5A5A);
        repeat (5) @(negedge clk);
        ms = 1'b1; key = 64'hFFFF0000FFFF0000; dec = 1'b1;
        mode = MODE_ECB; iv = 64'h0F0F0F0F0F0F0F0F;
        @(negedge clk);
        ms = 1'b0;
        check("wait_ms_key", dkey, K);
        recv(0, g1);
        send(64'h8877665544332211, 1'b0, K, 1'b0, MODE_CBC, 64'd0);
        recv(0, g1);

        send(64'h0BADC0DE0BADC0DE, 1'b1, 64'h0123456789ABCDEF,
             1'b1, MODE_CBC, 64'h1111111111111111);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_back());
        model_reset();
        repeat (25) @(negedge clk);
        check("stale_done_ignored", {63'd0, bus.o_OutValid}, 64'd0);
        send(P, 1'b1, K, 1'b0, MODE_ECB, 64'd0);
        recv(0, g1);
        check("post_rst_kat", g1, C);

        for (int i = 0; i < 3; i++) begin
            send({$urandom, $urandom}, 1'b1, {$urandom, $urandom},
                 1'($urandom_range(1)), 1'($urandom_range(1)),
                 {$urandom, $urandom});
            recv(i, g1);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
